// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 16-bit LFSR pattern stream (taps 15,14,12,3).
// Self-synchronises, confirms lock, then flywheels its prediction and counts mismatches.
module lfsr_stream_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      data_in,
    input  logic             data_valid,
    input  logic             clear_count,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [15:0]      expected,
    output logic [1:0]       state
);

    localparam int unsigned W     = 16;
    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       expected_q, expected_d;
    logic [RUN_W-1:0]   match_run_q, match_run_d;
    logic [RUN_W-1:0]   miss_run_q, miss_run_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               error_q, error_d;
    logic               count_miss;
    logic               hit;
    logic [RUN_W-1:0]   match_inc;
    logic [RUN_W-1:0]   miss_inc;

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] w);
        return {w[14:0], w[15] ^ w[14] ^ w[12] ^ w[3]};
    endfunction

    assign hit       = (data_in == expected_q);
    assign match_inc = match_run_q + RUN_W'(1);
    assign miss_inc  = miss_run_q + RUN_W'(1);

    // Next-state and predictor update; only valid beats move anything.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        error_d     = 1'b0;
        count_miss  = 1'b0;

        if (data_valid) begin
            case (state_q)
                CONFIRM: begin
                    if (hit) begin
                        expected_d  = lfsr_next(data_in);
                        match_run_d = match_inc;
                        if (match_inc == RUN_W'(LOCK_COUNT)) begin
                            state_d    = LOCKED;
                            miss_run_d = '0;
                        end
                    end else if (data_in != '0) begin
                        expected_d  = lfsr_next(data_in);
                        match_run_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: received data never reloads the predictor here.
                    expected_d = lfsr_next(expected_q);
                    if (hit) begin
                        miss_run_d = '0;
                    end else begin
                        error_d    = 1'b1;
                        count_miss = 1'b1;
                        miss_run_d = miss_inc;
                        if (miss_inc == RUN_W'(LOSS_COUNT)) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    if (data_in != '0) begin
                        expected_d  = lfsr_next(data_in);
                        match_run_d = '0;
                        state_d     = CONFIRM;
                    end else begin
                        state_d = HUNT;
                    end
                end
            endcase
        end

        err_count_d = err_count_q;
        if (clear_count) begin
            err_count_d = '0;
        end else if (count_miss && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            match_run_q <= '0;
            miss_run_q  <= '0;
            err_count_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            err_count_q <= err_count_d;
            error_q     <= error_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign error     = error_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Scoreboard bench for lfsr_stream_checker: directed beats push expected results,
// a monitor pops one record per clock and compares both DUT instances.
module tb_lfsr_stream_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        data_valid;
    logic        clear_count;

    logic        locked, error, locked4, error4;
    logic [15:0] err_count, expected, expected4;
    logic [3:0]  err_count4;
    logic [1:0]  state, state4;

    always #5 clk = ~clk;

    lfsr_stream_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clear_count(clear_count), .locked(locked), .error(error),
        .err_count(err_count), .expected(expected), .state(state)
    );

    lfsr_stream_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clear_count(clear_count), .locked(locked4), .error(error4),
        .err_count(err_count4), .expected(expected4), .state(state4)
    );

    typedef struct {
        logic [1:0]  st;
        logic        err;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
        logic [15:0] exp;
        string       nm;
    } rec_t;

    rec_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] w;       // next correct word of the source stream
    logic [15:0] e_cnt;   // expected err_count after the current beat

    function automatic logic [15:0] nxt(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[14] ^ x[12] ^ x[3]};
    endfunction

    task automatic chk(input string nm, input string f, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s %s: got %0h want %0h", nm, f, got, want);
        end
    endtask

    // Apply one cycle of inputs and queue the outputs expected after that edge.
    task automatic drive(input logic rst, input logic v, input logic clr, input logic [15:0] d,
                         input logic [1:0] st, input logic err, input logic [15:0] exp, input string nm);
        rec_t r;
        @(negedge clk);
        reset       = rst;
        data_valid  = v;
        clear_count = clr;
        data_in     = d;
        r.st   = st;
        r.err  = err;
        r.cnt  = e_cnt;
        r.cnt4 = (e_cnt > 16'd15) ? 4'd15 : e_cnt[3:0];
        r.exp  = exp;
        r.nm   = nm;
        sb.push_back(r);
    endtask

    task automatic good_beat(input logic [1:0] st, input string nm);
        drive(1'b0, 1'b1, 1'b0, w, st, 1'b0, nxt(w), nm);
        w = nxt(w);
    endtask

    // Corrupted word while locked: prediction still advances to nxt(w).
    task automatic bad_beat(input logic [1:0] st, input logic clr, input string nm);
        e_cnt = clr ? 16'd0 : e_cnt + 16'd1;
        drive(1'b0, 1'b1, clr, w ^ 16'h0001, st, 1'b1, nxt(w), nm);
        w = nxt(w);
    endtask

    task automatic idle(input logic [1:0] st, input logic [15:0] exp, input string nm);
        drive(1'b0, 1'b0, 1'b0, ~w, st, 1'b0, exp, nm);
    endtask

    // Monitor: one record per clock, sampled away from the active edge.
    always begin
        rec_t r;
        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            r = sb.pop_front();
            chk(r.nm, "state",      {14'd0, state},       {14'd0, r.st});
            chk(r.nm, "locked",     {15'd0, locked},      {15'd0, (r.st == 2'd2)});
            chk(r.nm, "error",      {15'd0, error},       {15'd0, r.err});
            chk(r.nm, "err_count",  err_count,            r.cnt);
            chk(r.nm, "expected",   expected,             r.exp);
            chk(r.nm, "err_count4", {12'd0, err_count4},  {12'd0, r.cnt4});
            chk(r.nm, "state4",     {14'd0, state4},      {14'd0, r.st});
            chk(r.nm, "error4",     {15'd0, error4},      {15'd0, r.err});
            chk(r.nm, "expected4",  expected4,            r.exp);
        end
    end

    initial begin
        reset       = 1'b1;
        data_valid  = 1'b0;
        clear_count = 1'b0;
        data_in     = 16'h0000;
        e_cnt       = 16'd0;
        w           = 16'h4040;

        drive(1'b1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0, "reset");
        drive(1'b1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0, "reset");

        // Lockup word keeps HUNT
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 16'h0, "hunt_zero");

        // Acquire: 0x4040 -> CONFIRM (exp 8081), 0x8081 -> exp 0103, lock on 5th beat
        for (int i = 0; i < 5; i++) good_beat((i == 4) ? 2'd2 : 2'd1, "acquire");
        for (int i = 0; i < 3; i++) good_beat(2'd2, "locked_run");

        // Single corrupted word, flywheel keeps matching afterwards
        bad_beat(2'd2, 1'b0, "single_err");
        good_beat(2'd2, "after_err");
        good_beat(2'd2, "after_err");

        // Miss run broken by a match never reaches LOSS_COUNT
        bad_beat(2'd2, 1'b0, "miss_run");
        bad_beat(2'd2, 1'b0, "miss_run");
        good_beat(2'd2, "miss_reset");
        bad_beat(2'd2, 1'b0, "miss_run");
        bad_beat(2'd2, 1'b0, "miss_run");
        good_beat(2'd2, "miss_reset");

        // Three consecutive misses drop to HUNT on the third
        bad_beat(2'd2, 1'b0, "loss");
        bad_beat(2'd2, 1'b0, "loss");
        bad_beat(2'd0, 1'b0, "loss_hunt");
        idle(2'd0, w, "idle_hunt");

        // CONFIRM: zero word falls back to HUNT, nonzero mismatch resyncs
        good_beat(2'd1, "confirm");
        drive(1'b0, 1'b1, 1'b0, 16'h0, 2'd0, 1'b0, w, "confirm_zero");
        good_beat(2'd1, "confirm");
        w = w ^ 16'h0001;
        good_beat(2'd1, "resync");
        for (int i = 0; i < 4; i++) good_beat((i == 3) ? 2'd2 : 2'd1, "relock");

        // Gapped valid while locked
        for (int i = 0; i < 4; i++) begin
            idle(2'd2, w, "gap_idle");
            good_beat(2'd2, "gap_beat");
        end
        bad_beat(2'd2, 1'b0, "gap_err");
        idle(2'd2, w, "gap_err_idle");
        good_beat(2'd2, "gap_beat");
        idle(2'd2, w, "gap_idle");

        // Plain clear, then 20 isolated misses: 4-bit counter saturates at 15
        e_cnt = 16'd0;
        drive(1'b0, 1'b1, 1'b1, w, 2'd2, 1'b0, nxt(w), "clear_plain");
        w = nxt(w);
        for (int i = 0; i < 20; i++) begin
            bad_beat(2'd2, 1'b0, "sat_err");
            good_beat(2'd2, "sat_ok");
        end
        bad_beat(2'd2, 1'b1, "clear_vs_err");
        good_beat(2'd2, "after_clear");

        // Lose lock, then relock with gapped valid
        bad_beat(2'd2, 1'b0, "loss2");
        bad_beat(2'd2, 1'b0, "loss2");
        bad_beat(2'd0, 1'b0, "loss2_hunt");
        for (int i = 0; i < 5; i++) begin
            idle((i == 0) ? 2'd0 : 2'd1, w, "gap_lock_idle");
            good_beat((i == 4) ? 2'd2 : 2'd1, "gap_lock");
        end

        // Reset mid-LOCKED with a valid beat present
        e_cnt = 16'd0;
        drive(1'b1, 1'b1, 1'b0, w, 2'd0, 1'b0, 16'h0, "reset_mid");
        idle(2'd0, 16'h0, "post_reset");
        good_beat(2'd1, "post_reset_beat");

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #5;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d records left want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Receive-side counterpart of the 16-bit LFSR pattern generator: checks a stream of 16-bit LFSR words, one word per valid beat.
- The source LFSR uses taps 15, 14, 12, 3, shifts left, and feeds the XOR result into bit 0.
- The block self-synchronises to the incoming stream, confirms lock, then flywheels its own prediction. It flags mismatched words and keeps a saturating error count.
- Used on the pattern-loopback path to qualify datapaths driven by the generator.

Parameters:
- LOCK_COUNT, 4: consecutive correctly predicted words needed in CONFIRM before entering LOCKED (legal 1..15).
- LOSS_COUNT, 3: consecutive mismatched words in LOCKED that force a return to HUNT (legal 1..15).
- CNT_W, 16: width of err_count.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- data_in  in  16  received LFSR word.
- data_valid  in  1  data_in is sampled on this cycle.
- clear_count  in  1  synchronous clear of err_count.
- locked  out  1  high while state is LOCKED.
- error  out  1  one-cycle pulse: previous valid beat mismatched while LOCKED.
- err_count  out  CNT_W  saturating count of LOCKED mismatches.
- expected  out  16  word predicted for the next valid beat.
- state  out  2  HUNT=0, CONFIRM=1, LOCKED=2 (3 unused, decodes to HUNT).

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- next(w) = {w[14:0], w[15]^w[14]^w[12]^w[3]}.
- Reset values: state=HUNT, locked=0, error=0, err_count=0, expected=0, internal match/miss run counters=0. A reset asserted in any state, mid-stream, takes priority over all other inputs on that edge.
- Cycles with data_valid=0: no state or counter change; error is 0.
- HUNT, on a valid beat:
  - data_in=0 (the lockup word): stay in HUNT.
  - Otherwise: expected<=next(data_in), match_run<=0, go to CONFIRM.
- CONFIRM, on a valid beat:
  - data_in==expected: expected<=next(data_in), match_run++. When match_run+1==LOCK_COUNT, go to LOCKED and clear miss_run.
  - Mismatch with data_in!=0: expected<=next(data_in), match_run<=0, stay in CONFIRM (resynchronise on the new word).
  - Mismatch with data_in==0: go to HUNT.
  - error is never asserted and err_count is never changed in CONFIRM.
- LOCKED, on a valid beat:
  - expected<=next(expected) always. This is flywheel operation: received data never reloads the predictor while locked.
  - Match: miss_run<=0.
  - Mismatch: error=1 on the next cycle, err_count++ (saturates at 2^CNT_W-1 with no wrap), miss_run++.
  - When miss_run+1==LOSS_COUNT: go to HUNT on the same edge. The error for that beat is still pulsed and counted.
- Latency:
  - locked rises on the edge that samples the LOCK_COUNT-th consecutive match.
  - error is registered and high for exactly the one cycle after the offending beat. Back-to-back mismatches give consecutive error cycles.
  - locked falls on the edge that samples the LOSS_COUNT-th consecutive miss.
- clear_count:
  - Clears err_count in any state.
  - If it coincides with a counted mismatch, the clear wins: err_count=0, error still pulses.
- locked is combinationally decoded from the state register; all other outputs are registers.

Test Plan:
- Reset, then feed 0x4040, 0x8081, 0x0103, then continued next() words with LOCK_COUNT=4 -> state goes HUNT->CONFIRM after beat 1; locked=1 after the 5th beat; error stays 0; expected=0x0103 after beat 2.
- Locked stream with one word corrupted (bit 0 flipped), then the correct sequence resumes -> single 1-cycle error pulse, err_count=1, locked stays 1, subsequent words match because of flywheel prediction.
- Locked, then 3 consecutive wrong words with LOSS_COUNT=3 -> three error pulses, err_count=3, state=HUNT and locked=0 after the 3rd beat. Valid stream afterwards relocks after 5 beats.
- data_valid toggling 1/0 every cycle during lock and check -> result identical to the contiguous case; idle cycles change nothing.
- CNT_W=4, 20 isolated mismatches interleaved with matches -> err_count saturates at 15. clear_count coincident with a mismatch -> err_count=0, error=1.
- HUNT fed 0x0000 repeatedly -> stays in HUNT. Reset asserted mid-LOCKED -> all outputs return to reset values on the next edge.
